uint_mul_accumulate: RTL and testbench

- Downstream consumer of the unsigned WIDTH-bit multiplier stage.
- Accepts one product per valid/ready handshake and sums COUNT consecutive products into an ACC_WIDTH-bit accumulator.
- Presents each completed sum, plus a sticky overflow flag, on a valid/ready output port.
- The multiplier output is already truncated mod 2^WIDTH; this block zero-extends it.

---
 rtl/uint_mul_accumulate.sv | 92 +++++++++
 tb/tb_uint_mul_accumulate.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uint_mul_accumulate.sv
// Sums COUNT consecutive zero-extended products into one result and presents
// it, with a per-group sticky carry-out flag, on a valid/ready output port.
module uint_mul_accumulate #(
  parameter int WIDTH     = 3,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic [WIDTH-1:0]     I,
  input  logic                 I_valid,
  output logic                 I_ready,
  input  logic                 clear,
  output logic [ACC_WIDTH-1:0] O,
  output logic                 O_valid,
  input  logic                 O_ready,
  output logic                 O_overflow
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t               state_reg;
  logic [ACC_WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 run_ovf_reg;
  logic [ACC_WIDTH-1:0] o_reg;
  logic                 o_valid_reg;
  logic                 o_ovf_reg;

  logic                 beat;
  logic [ACC_WIDTH:0]   sum;

  // clear blocks acceptance so a product offered alongside it stays pending
  assign I_ready = (state_reg == ACCUM) && !clear;
  assign beat    = I_valid && I_ready;
  assign sum     = {1'b0, acc_reg} + (ACC_WIDTH + 1)'(I);

  assign O          = o_reg;
  assign O_valid    = o_valid_reg;
  assign O_overflow = o_ovf_reg;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_reg   <= ACCUM;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      run_ovf_reg <= 1'b0;
      o_reg       <= '0;
      o_valid_reg <= 1'b0;
      o_ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (clear) begin
            acc_reg     <= '0;
            cnt_reg     <= '0;
            run_ovf_reg <= 1'b0;
          end else if (beat) begin
            if (cnt_reg == LAST_CNT) begin
              o_reg       <= sum[ACC_WIDTH-1:0];
              o_ovf_reg   <= run_ovf_reg | sum[ACC_WIDTH];
              o_valid_reg <= 1'b1;
              acc_reg     <= '0;
              cnt_reg     <= '0;
              run_ovf_reg <= 1'b0;
              state_reg   <= HOLD;
            end else begin
              acc_reg     <= sum[ACC_WIDTH-1:0];
              run_ovf_reg <= run_ovf_reg | sum[ACC_WIDTH];
              cnt_reg     <= cnt_reg + 1'b1;
            end
          end
        end
        HOLD: begin
          // O and O_overflow deliberately keep their value after the handshake
          if (O_ready) begin
            o_valid_reg <= 1'b0;
            state_reg   <= ACCUM;
          end
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_uint_mul_accumulate.sv
// Bench for uint_mul_accumulate: three instances (defaults, ACC_WIDTH=4, COUNT=1)
// driven by directed and random groups, checked against plain-arithmetic sums.
module tb_uint_mul_accumulate;

  localparam int N = 3;

  logic         CLK = 1'b0;
  logic         RESETN;
  logic [2:0]   i_s [N];
  logic [N-1:0] iv_s;
  logic [N-1:0] clr_s;
  logic [N-1:0] ordy_s;
  logic [N-1:0] ir_w;
  logic [N-1:0] ov_w;
  logic [N-1:0] oo_w;
  logic [7:0]   o_a;
  logic [3:0]   o_b;
  logic [7:0]   o_c;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  uint_mul_accumulate u_def (
    .CLK(CLK), .RESETN(RESETN), .I(i_s[0]), .I_valid(iv_s[0]), .I_ready(ir_w[0]),
    .clear(clr_s[0]), .O(o_a), .O_valid(ov_w[0]), .O_ready(ordy_s[0]), .O_overflow(oo_w[0])
  );

  uint_mul_accumulate #(.WIDTH(3), .ACC_WIDTH(4), .COUNT(4)) u_acc4 (
    .CLK(CLK), .RESETN(RESETN), .I(i_s[1]), .I_valid(iv_s[1]), .I_ready(ir_w[1]),
    .clear(clr_s[1]), .O(o_b), .O_valid(ov_w[1]), .O_ready(ordy_s[1]), .O_overflow(oo_w[1])
  );

  uint_mul_accumulate #(.WIDTH(3), .ACC_WIDTH(8), .COUNT(1)) u_cnt1 (
    .CLK(CLK), .RESETN(RESETN), .I(i_s[2]), .I_valid(iv_s[2]), .I_ready(ir_w[2]),
    .clear(clr_s[2]), .O(o_c), .O_valid(ov_w[2]), .O_ready(ordy_s[2]), .O_overflow(oo_w[2])
  );

  function automatic logic [7:0] get_o(input int d);
    if (d == 0) return o_a;
    else if (d == 1) return {4'b0000, o_b};
    else return o_c;
  endfunction

  function automatic int acc_w(input int d);
    return (d == 1) ? 4 : 8;
  endfunction

  function automatic int group_len(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  // Offer v on instance d after an optional idle gap; the beat lands on the next rising edge.
  task automatic push(input int d, input logic [2:0] v, input int max_gap);
    int gaps;
    int waited;
    gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gaps) begin
      @(negedge CLK);
      iv_s[d] = 1'b0;
      i_s[d]  = 3'($urandom);
    end
    @(negedge CLK);
    i_s[d]   = v;
    iv_s[d]  = 1'b1;
    clr_s[d] = 1'b0;
    #1;
    waited = 0;
    while (!ir_w[d] && waited < 50) begin
      @(negedge CLK);
      #1;
      waited++;
    end
    if (!ir_w[d]) begin
      total++;
      bad++;
      $display("FAIL push_ready dut%0d I_ready got=0 want=1 within 50 cycles", d);
    end
  endtask

  // Called right after the last push: result must be valid the cycle after that beat.
  task automatic expect_result(input int d, input string name, input int exp_o, input logic exp_ovf);
    @(negedge CLK);
    iv_s[d] = 1'b0;
    #1;
    total++;
    if (ov_w[d] !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid dut%0d got=%0b want=1", name, d, ov_w[d]);
    end
    total++;
    if (get_o(d) !== 8'(exp_o)) begin
      bad++;
      $display("FAIL %s_O dut%0d got=%0d want=%0d", name, d, get_o(d), exp_o);
    end
    total++;
    if (oo_w[d] !== exp_ovf) begin
      bad++;
      $display("FAIL %s_ovf dut%0d got=%0b want=%0b", name, d, oo_w[d], exp_ovf);
    end
    total++;
    if (ir_w[d] !== 1'b0) begin
      bad++;
      $display("FAIL %s_ready_in_hold dut%0d got=%0b want=0", name, d, ir_w[d]);
    end
    $display("result %s dut%0d O=%0d ovf=%0b (want %0d/%0b)", name, d, get_o(d), oo_w[d], exp_o, exp_ovf);
    if (ordy_s[d]) begin
      @(negedge CLK);
      #1;
      total++;
      if (ov_w[d] !== 1'b0) begin
        bad++;
        $display("FAIL %s_one_cycle dut%0d O_valid got=%0b want=0", name, d, ov_w[d]);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    #1;
    for (int d = 0; d < N; d++) begin
      total++;
      if (get_o(d) !== 8'd0 || ov_w[d] !== 1'b0 || oo_w[d] !== 1'b0) begin
        bad++;
        $display("FAIL reset_state dut%0d O=%0d valid=%0b ovf=%0b want 0/0/0", d, get_o(d), ov_w[d], oo_w[d]);
      end
    end
    RESETN = 1'b1;
    ordy_s[0] = 1'b0;
    for (int k = 0; k < 4; k++) push(0, 3'd7, 0);
    expect_result(0, "pre_reset", 28, 1'b0);
    @(negedge CLK);
    RESETN = 1'b0;
    @(negedge CLK);
    #1;
    total++;
    if (get_o(0) !== 8'd0 || ov_w[0] !== 1'b0 || oo_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_in_hold O=%0d valid=%0b ovf=%0b want 0/0/0", get_o(0), ov_w[0], oo_w[0]);
    end
    @(negedge CLK);
    RESETN = 1'b1;
    @(negedge CLK);
    #1;
    total++;
    if (ir_w[0] !== 1'b1 || ov_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL reset_release I_ready=%0b O_valid=%0b want 1/0", ir_w[0], ov_w[0]);
    end
  endtask

  task automatic test_basic();
    ordy_s[0] = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 3'd7, 0);
    expect_result(0, "basic", 28, 1'b0);
  endtask

  task automatic test_backpressure();
    ordy_s[0] = 1'b0;
    push(0, 3'd1, 0);
    push(0, 3'd2, 0);
    push(0, 3'd3, 0);
    push(0, 3'd4, 0);
    expect_result(0, "bp_first", 10, 1'b0);
    i_s[0]  = 3'd5;
    iv_s[0] = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      #1;
      total++;
      if (ir_w[0] !== 1'b0 || ov_w[0] !== 1'b1 || get_o(0) !== 8'd10) begin
        bad++;
        $display("FAIL bp_hold I_ready=%0b O_valid=%0b O=%0d want 0/1/10", ir_w[0], ov_w[0], get_o(0));
      end
    end
    ordy_s[0] = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 3'd5, 0);
    expect_result(0, "bp_second", 20, 1'b0);
  endtask

  task automatic test_overflow();
    ordy_s[1] = 1'b1;
    for (int k = 0; k < 4; k++) push(1, 3'd7, 0);
    expect_result(1, "ovf_wrap", 12, 1'b1);
    for (int k = 0; k < 4; k++) push(1, 3'd1, 0);
    expect_result(1, "ovf_next", 4, 1'b0);
  endtask

  task automatic test_clear();
    ordy_s[0] = 1'b1;
    push(0, 3'd5, 0);
    push(0, 3'd3, 0);
    @(negedge CLK);
    i_s[0]   = 3'd6;
    iv_s[0]  = 1'b1;
    clr_s[0] = 1'b1;
    #1;
    total++;
    if (ir_w[0] !== 1'b0) begin
      bad++;
      $display("FAIL clear_blocks I_ready=%0b want 0", ir_w[0]);
    end
    push(0, 3'd6, 0);
    push(0, 3'd1, 0);
    push(0, 3'd2, 0);
    push(0, 3'd3, 0);
    expect_result(0, "clear_accum", 12, 1'b0);
    ordy_s[0] = 1'b0;
    for (int k = 0; k < 4; k++) push(0, 3'd1, 0);
    expect_result(0, "clear_pre_hold", 4, 1'b0);
    clr_s[0] = 1'b1;
    repeat (2) begin
      @(negedge CLK);
      #1;
      total++;
      if (ov_w[0] !== 1'b1 || get_o(0) !== 8'd4) begin
        bad++;
        $display("FAIL clear_in_hold O_valid=%0b O=%0d want 1/4", ov_w[0], get_o(0));
      end
    end
    clr_s[0]  = 1'b0;
    ordy_s[0] = 1'b1;
    @(negedge CLK);
    #1;
    total++;
    if (ov_w[0] !== 1'b0 || get_o(0) !== 8'd4) begin
      bad++;
      $display("FAIL clear_after_handshake O_valid=%0b O=%0d want 0/4", ov_w[0], get_o(0));
    end
  endtask

  task automatic test_bubbles();
    ordy_s[0] = 1'b1;
    push(0, 3'd2, 3);
    push(0, 3'd3, 3);
    push(0, 3'd1, 3);
    push(0, 3'd4, 3);
    expect_result(0, "bubbles", 10, 1'b0);
  endtask

  task automatic test_count1();
    ordy_s[2] = 1'b1;
    push(2, 3'd7, 0);
    expect_result(2, "count1_a", 7, 1'b0);
    push(2, 3'd0, 0);
    expect_result(2, "count1_b", 0, 1'b0);
  endtask

  // Random groups: expected result is the true sum mod 2^ACC_WIDTH, and overflow
  // is set exactly when the true (unbounded) group sum reaches 2^ACC_WIDTH.
  task automatic test_random();
    int   sum;
    int   exp_o;
    logic exp_ovf;
    logic [2:0] v;
    for (int d = 0; d < N; d++) begin
      for (int g = 0; g < 6; g++) begin
        ordy_s[d] = 1'($urandom_range(1, 0));
        sum = 0;
        for (int k = 0; k < group_len(d); k++) begin
          v = 3'($urandom_range(7, 0));
          sum += int'(v);
          push(d, v, 2);
        end
        exp_o   = sum % (1 << acc_w(d));
        exp_ovf = (sum >= (1 << acc_w(d)));
        expect_result(d, "random", exp_o, exp_ovf);
        if (!ordy_s[d]) begin
          repeat (int'($urandom_range(3, 1))) begin
            @(negedge CLK);
            #1;
            total++;
            if (ov_w[d] !== 1'b1 || get_o(d) !== 8'(exp_o)) begin
              bad++;
              $display("FAIL random_hold dut%0d O_valid=%0b O=%0d want 1/%0d", d, ov_w[d], get_o(d), exp_o);
            end
          end
          ordy_s[d] = 1'b1;
          @(negedge CLK);
          #1;
          total++;
          if (ov_w[d] !== 1'b0) begin
            bad++;
            $display("FAIL random_release dut%0d O_valid=%0b want 0", d, ov_w[d]);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESETN = 1'b0;
    for (int d = 0; d < N; d++) i_s[d] = 3'd0;
    iv_s   = '0;
    clr_s  = '0;
    ordy_s = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_overflow();
    test_clear();
    test_bubbles();
    test_count1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
